// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic cells.
//   DEFAULT_WIDTH : default operand width for serial datapaths
//   state_t       : sequencing FSM encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start/busy/done handshake plus operand/result bus of the serial subtractor.
//   start, a, b          : request and operands (driven by the controller)
//   busy, done, diff,
//   bout                 : status and result (driven by the subtractor)
//   ovf                  : signed overflow, present only with SERIAL_SUB_OVERFLOW_EN
// Modports: master = controlling FSM side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Gate-level one-bit full subtractor: x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_xor_y;

    assign x_xor_y = x ^ y;
    assign d       = x_xor_y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bout    = (~x & y) | (~x_xor_y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial diff = a - b, LSB first, one bit per clock through a single
// full_subtractor cell and a registered borrow. One operation takes WIDTH
// RUN cycles plus one DONE cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (start, a, b, busy, done, diff, bout
//           and, with SERIAL_SUB_OVERFLOW_EN defined, ovf)
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds signed overflow (ovf).
//
// state | meaning
// IDLE  | waiting for start; diff/bout hold the last result
// RUN   | one result bit per edge, WIDTH edges
// DONE  | done pulse for one cycle, start ignored
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             bout_q;
    logic             cell_d;
    logic             cell_b;
    logic             last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign last_bit = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sa     <= '0;
            sb     <= '0;
            diff_q <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        borrow <= 1'b0;
                        count  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // Operand MSBs are shifted out by the end, keep copies.
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    // Result fills from the MSB end so it lands aligned after WIDTH shifts.
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    borrow <= cell_b;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        bout_q <= cell_b;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // cell_d is the result MSB on this final edge.
                        ovf_q  <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
